// File: rtl/mcast_pkg.sv
// Shared types and constants for the XY multicast bus controller.
package mcast_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned TAG_WIDTH  = 4;
  localparam int unsigned DROP_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DELIVER
  } state_t;

  typedef logic [TAG_WIDTH-1:0] id_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    id_t                   row_tag;
    id_t                   col_tag;
  } packet_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/mcast_fifo.sv
// Synchronous packet FIFO with occupancy count and synchronous flush.
module mcast_fifo
  import mcast_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  packet_t          i_data,
  output packet_t          o_head_c,
  output logic [CNT_W-1:0] o_count
);

  packet_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_count  = r_count;

endmodule

// File: rtl/xy_multicast_bus_ctrl.sv
// Multicast controller: buffers tagged packets and delivers each one to every PE
// whose row X_ID and per-PE Y_ID match, retiring it once all targets accepted.
module xy_multicast_bus_ctrl
  import mcast_pkg::*;
#(
  parameter  int unsigned NUM_ROW    = 3,
  parameter  int unsigned NUM_COL    = 3,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned NUM_PE     = NUM_ROW * NUM_COL,
  localparam int unsigned ADDR_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  cfg_we,
  input  logic                  cfg_is_row,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [TAG_WIDTH-1:0]  cfg_id,
  output logic                  cfg_err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [TAG_WIDTH-1:0]  s_row_tag,
  input  logic [TAG_WIDTH-1:0]  s_col_tag,
  output logic [NUM_PE-1:0]     pe_valid,
  input  logic [NUM_PE-1:0]     pe_ready,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic                  busy,
  output logic [DROP_W-1:0]     drop_cnt
);

  state_t                r_state;
  state_t                w_state_next;
  logic [NUM_PE-1:0]     r_pending;
  logic [NUM_PE-1:0]     w_pending_next;
  logic [NUM_PE-1:0]     w_mask;
  logic [DATA_WIDTH-1:0] r_pe_data;
  logic [DROP_W-1:0]     r_drop_cnt;
  logic                  r_cfg_err;
  logic                  r_s_ready;
  logic                  r_busy;
  id_t                   r_x_id [NUM_ROW];
  id_t                   r_y_id [NUM_PE];

  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_drop;
  logic                  w_fifo_nempty;
  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_count_next;
  packet_t               w_in_pkt;
  packet_t               w_head;
  logic                  w_cfg_idle;
  logic                  w_addr_ok;
  logic                  w_cfg_ok;

  assign w_push        = s_valid && r_s_ready && !flush;
  assign w_fifo_nempty = (w_count != '0);
  assign w_in_pkt      = '{data: s_data, row_tag: s_row_tag, col_tag: s_col_tag};

  mcast_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (flush),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_data   (w_in_pkt),
    .o_head_c (w_head),
    .o_count  (w_count)
  );

  // Target mask of the head packet against the current ID tables.
  always_comb begin
    w_mask = '0;
    for (int unsigned r = 0; r < NUM_ROW; r++) begin
      for (int unsigned c = 0; c < NUM_COL; c++) begin
        w_mask[r*NUM_COL+c] = (r_x_id[r] == w_head.row_tag) &&
                              (r_y_id[r*NUM_COL+c] == w_head.col_tag);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // An incoming push counts as available work so a fresh packet loads the next cycle.
  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_pop          = 1'b0;
    w_load         = 1'b0;
    w_drop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fifo_nempty || w_push) w_state_next = LOAD;
      end
      LOAD: begin
        w_pop          = 1'b1;
        w_load         = 1'b1;
        w_pending_next = w_mask;
        if (w_mask == '0) begin
          w_drop       = 1'b1;
          w_state_next = ((w_count > CNT_W'(1)) || w_push) ? LOAD : IDLE;
        end else begin
          w_state_next = DELIVER;
        end
      end
      DELIVER: begin
        w_pending_next = r_pending & ~pe_ready;
        if (w_pending_next == '0) begin
          w_state_next = (w_fifo_nempty || w_push) ? LOAD : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) begin
      w_state_next   = IDLE;
      w_pending_next = '0;
      w_pop          = 1'b0;
      w_load         = 1'b0;
      w_drop         = 1'b0;
    end
  end

  always_comb begin
    w_count_next = w_count;
    if (flush)                w_count_next = '0;
    else if (w_push && !w_pop) w_count_next = w_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_next = w_count - CNT_W'(1);
  end

  assign w_cfg_idle = (r_state == IDLE) && !w_fifo_nempty;
  assign w_addr_ok  = cfg_is_row ? ({1'b0, cfg_addr} < (ADDR_W+1)'(NUM_ROW))
                                 : ({1'b0, cfg_addr} < (ADDR_W+1)'(NUM_PE));
  assign w_cfg_ok   = cfg_we && w_cfg_idle && w_addr_ok;

  // Pending mask only ever holds bits while delivering, so it drives pe_valid directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_pe_data  <= '0;
      r_drop_cnt <= '0;
      r_cfg_err  <= 1'b0;
      r_s_ready  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (w_load) r_pe_data  <= w_head.data;
      if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
      r_cfg_err <= cfg_we && !(w_cfg_idle && w_addr_ok);
      r_s_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
      r_busy    <= (w_count_next != '0) || (w_state_next != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_ROW; r++) begin
        r_x_id[r] <= TAG_WIDTH'(r);
        for (int unsigned c = 0; c < NUM_COL; c++) begin
          r_y_id[r*NUM_COL+c] <= TAG_WIDTH'(c);
        end
      end
    end else begin
      for (int unsigned r = 0; r < NUM_ROW; r++) begin
        if (w_cfg_ok && cfg_is_row && (cfg_addr == ADDR_W'(r))) r_x_id[r] <= cfg_id;
      end
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (w_cfg_ok && !cfg_is_row && (cfg_addr == ADDR_W'(i))) r_y_id[i] <= cfg_id;
      end
    end
  end

  assign pe_valid = r_pending;
  assign pe_data  = r_pe_data;
  assign drop_cnt = r_drop_cnt;
  assign cfg_err  = r_cfg_err;
  assign s_ready  = r_s_ready;
  assign busy     = r_busy;

endmodule

// File: tb/tb_xy_multicast_bus_ctrl.sv
// Directed self-checking bench for the 3x3 multicast controller.
module tb_xy_multicast_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        cfg_we;
  logic        cfg_is_row;
  logic [3:0]  cfg_addr;
  logic [3:0]  cfg_id;
  logic        cfg_err;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [3:0]  s_row_tag;
  logic [3:0]  s_col_tag;
  logic [8:0]  pe_valid;
  logic [8:0]  pe_ready;
  logic [15:0] pe_data;
  logic        busy;
  logic [15:0] drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  xy_multicast_bus_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .cfg_we     (cfg_we),
    .cfg_is_row (cfg_is_row),
    .cfg_addr   (cfg_addr),
    .cfg_id     (cfg_id),
    .cfg_err    (cfg_err),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_row_tag  (s_row_tag),
    .s_col_tag  (s_col_tag),
    .pe_valid   (pe_valid),
    .pe_ready   (pe_ready),
    .pe_data    (pe_data),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] r, input logic [3:0] c);
    s_valid = 1'b1; s_data = d; s_row_tag = r; s_col_tag = c;
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; cfg_we = 1'b0; cfg_is_row = 1'b0; cfg_addr = '0; cfg_id = '0;
    s_valid = 1'b0; s_data = '0; s_row_tag = '0; s_col_tag = '0; pe_ready = '1;
    step(); step();
    tests_run++; if (pe_valid !== 9'h000) begin tests_failed++; $display("FAIL reset_pe_valid: got %h want 000", pe_valid); end
    tests_run++; if (pe_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_pe_data: got %h want 0000", pe_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (drop_cnt !== 16'h0000) begin tests_failed++; $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt); end
    tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    rst = 1'b0;
    step();
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_single_delivery();
    pe_ready = '1;
    push(16'hABCD, 4'd1, 4'd2);
    tests_run++; if (pe_valid !== 9'h000) begin tests_failed++; $display("FAIL single_load_valid: got %h want 000", pe_valid); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_load_busy: got %b want 1", busy); end
    step();
    tests_run++; if (pe_valid !== 9'h020) begin tests_failed++; $display("FAIL single_valid: got %h want 020", pe_valid); end
    tests_run++; if (pe_data !== 16'hABCD) begin tests_failed++; $display("FAIL single_data: got %h want abcd", pe_data); end
    step();
    tests_run++; if (pe_valid !== 9'h000) begin tests_failed++; $display("FAIL single_retire: got %h want 000", pe_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_partial_accept();
    for (int i = 0; i < 9; i++) begin
      cfg_we = 1'b1; cfg_is_row = 1'b0; cfg_addr = 4'(i); cfg_id = 4'd0;
      step();
      tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL cfg_y_zero_err[%0d]: got %b want 0", i, cfg_err); end
    end
    cfg_we = 1'b0;
    pe_ready = 9'h000;
    push(16'h1234, 4'd0, 4'd0);
    step();
    tests_run++; if (pe_valid !== 9'h007) begin tests_failed++; $display("FAIL partial_mask: got %h want 007", pe_valid); end
    pe_ready = 9'h001;
    step();
    tests_run++; if (pe_valid !== 9'h006) begin tests_failed++; $display("FAIL partial_after_pe0: got %h want 006", pe_valid); end
    pe_ready = 9'h004;
    step();
    tests_run++; if (pe_valid !== 9'h002) begin tests_failed++; $display("FAIL partial_after_pe2: got %h want 002", pe_valid); end
    tests_run++; if (pe_data !== 16'h1234) begin tests_failed++; $display("FAIL partial_data_hold: got %h want 1234", pe_data); end
    pe_ready = 9'h002;
    step();
    tests_run++; if (pe_valid !== 9'h000) begin tests_failed++; $display("FAIL partial_retire: got %h want 000", pe_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL partial_busy: got %b want 0", busy); end
    for (int i = 0; i < 9; i++) begin
      cfg_we = 1'b1; cfg_is_row = 1'b0; cfg_addr = 4'(i); cfg_id = 4'(i % 3);
      step();
    end
    cfg_we = 1'b0;
    pe_ready = '1;
  endtask

  task automatic test_drop();
    s_valid = 1'b1; s_data = 16'h0777; s_row_tag = 4'd7; s_col_tag = 4'd0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) s_valid = 1'b0;
      step();
      tests_run++; if (pe_valid !== 9'h000) begin tests_failed++; $display("FAIL drop_no_valid[%0d]: got %h want 000", i, pe_valid); end
    end
    s_valid = 1'b0;
    tests_run++; if (drop_cnt !== 16'd3) begin tests_failed++; $display("FAIL drop_count3: got %0d want 3", drop_cnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL drop_busy: got %b want 0", busy); end
    force dut.r_drop_cnt = 16'hFFFE;
    step();
    release dut.r_drop_cnt;
    push(16'h0001, 4'd7, 4'd0);
    step(); step();
    tests_run++; if (drop_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL drop_reach_max: got %h want ffff", drop_cnt); end
    push(16'h0002, 4'd7, 4'd0);
    step(); step();
    tests_run++; if (drop_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL drop_saturate: got %h want ffff", drop_cnt); end
  endtask

  task automatic test_backpressure();
    int got;
    pe_ready = 9'h000;
    for (int k = 0; k < 5; k++) begin
      tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_before[%0d]: got %b want 1", k, s_ready); end
      s_valid = 1'b1; s_data = 16'(16'h0100 + k); s_row_tag = 4'd1; s_col_tag = 4'd1;
      step();
    end
    s_data = 16'hDEAD;
    tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full: got %b want 0", s_ready); end
    tests_run++; if (pe_valid !== 9'h010) begin tests_failed++; $display("FAIL bp_head_valid: got %h want 010", pe_valid); end
    tests_run++; if (pe_data !== 16'h0100) begin tests_failed++; $display("FAIL bp_head_data: got %h want 0100", pe_data); end
    step();
    s_valid = 1'b0;
    tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_still_full: got %b want 0", s_ready); end
    pe_ready = '1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (pe_valid != 9'h000) begin
        tests_run++;
        if (pe_valid !== 9'h010 || pe_data !== 16'(16'h0100 + got)) begin
          tests_failed++;
          $display("FAIL bp_order[%0d]: got valid %h data %h want valid 010 data %h", got, pe_valid, pe_data, 16'(16'h0100 + got));
        end
        got++;
      end
      step();
    end
    tests_run++; if (got !== 5) begin tests_failed++; $display("FAIL bp_count: got %0d want 5", got); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_drain_busy: got %b want 0", busy); end
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_drain_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_cfg_reject();
    pe_ready = 9'h000;
    push(16'h0055, 4'd0, 4'd0);
    step();
    tests_run++; if (pe_valid !== 9'h001) begin tests_failed++; $display("FAIL cfg_dlv_valid: got %h want 001", pe_valid); end
    cfg_we = 1'b1; cfg_is_row = 1'b1; cfg_addr = 4'd0; cfg_id = 4'd5;
    step();
    cfg_we = 1'b0;
    tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL cfg_busy_err: got %b want 1", cfg_err); end
    step();
    tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err); end
    pe_ready = '1;
    step(); step();
    push(16'h0066, 4'd0, 4'd0);
    step();
    tests_run++; if (pe_valid !== 9'h001) begin tests_failed++; $display("FAIL cfg_id_kept: got %h want 001", pe_valid); end
    step();
    cfg_we = 1'b1; cfg_is_row = 1'b0; cfg_addr = 4'd9; cfg_id = 4'd0;
    step();
    tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL cfg_pe_range: got %b want 1", cfg_err); end
    cfg_is_row = 1'b1; cfg_addr = 4'd3;
    step();
    tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL cfg_row_range: got %b want 1", cfg_err); end
    cfg_addr = 4'd2; cfg_id = 4'd9;
    step();
    cfg_we = 1'b0;
    tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL cfg_ok_err: got %b want 0", cfg_err); end
    push(16'h0077, 4'd9, 4'd1);
    step();
    tests_run++; if (pe_valid !== 9'h080) begin tests_failed++; $display("FAIL cfg_new_row_id: got %h want 080", pe_valid); end
    step();
    cfg_we = 1'b1; cfg_is_row = 1'b1; cfg_addr = 4'd2; cfg_id = 4'd2;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_flush();
    pe_ready = 9'h000;
    s_valid = 1'b1; s_row_tag = 4'd0; s_col_tag = 4'd0;
    for (int k = 0; k < 3; k++) begin
      s_data = 16'(k + 1);
      step();
    end
    tests_run++; if (pe_valid !== 9'h001) begin tests_failed++; $display("FAIL flush_pre_valid: got %h want 001", pe_valid); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    flush = 1'b1; s_data = 16'h0004;
    step();
    flush = 1'b0; s_valid = 1'b0;
    tests_run++; if (pe_valid !== 9'h000) begin tests_failed++; $display("FAIL flush_valid: got %h want 000", pe_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b want 0", busy); end
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %b want 1", s_ready); end
    pe_ready = '1;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++; if (pe_valid !== 9'h000) begin tests_failed++; $display("FAIL flush_quiet[%0d]: got %h want 000", k, pe_valid); end
    end
    tests_run++; if (drop_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL flush_keeps_drop: got %h want ffff", drop_cnt); end
  endtask

  task automatic test_reset_mid_deliver();
    pe_ready = 9'h000;
    push(16'h0009, 4'd1, 4'd2);
    step();
    tests_run++; if (pe_valid !== 9'h020) begin tests_failed++; $display("FAIL rstmid_pre_valid: got %h want 020", pe_valid); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (pe_valid !== 9'h000) begin tests_failed++; $display("FAIL rstmid_valid: got %h want 000", pe_valid); end
    tests_run++; if (pe_data !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_data: got %h want 0000", pe_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    tests_run++; if (drop_cnt !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_drop: got %h want 0000", drop_cnt); end
    @(negedge clk);
    rst = 1'b0;
    pe_ready = '1;
    step();
    push(16'hBEEF, 4'd1, 4'd2);
    step();
    tests_run++; if (pe_valid !== 9'h020) begin tests_failed++; $display("FAIL rstmid_after_valid: got %h want 020", pe_valid); end
    tests_run++; if (pe_data !== 16'hBEEF) begin tests_failed++; $display("FAIL rstmid_after_data: got %h want beef", pe_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_delivery();
    test_partial_accept();
    test_drop();
    test_backpressure();
    test_cfg_reject();
    test_flush();
    test_reset_mid_deliver();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
